ft_tx_arbiter: RTL

- Packet arbiter on the write side of the FT245 transmit FIFO, in the host-bound path.
- Shares the single tx FIFO between two byte-stream requesters: the command-response source and the CCD pixel-data source.
- Prefixes every granted chunk with a one-byte header identifying the source.
- Splits long packets into chunks of at most MAX_BURST bytes, so command responses are never starved behind a full pixel frame.

---
 rtl/ft_tx_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter: round-robin chunking arbiter feeding the FT245 tx FIFO from the cmd and pixel sources
module ft_tx_arbiter #(
   parameter int unsigned MAX_BURST = 64,
   parameter logic [7:0]  CMD_HDR   = 8'hA4,
   parameter logic [7:0]  PIX_HDR   = 8'h5A
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_data,
   input  logic       cmd_last,
   output logic       cmd_ready,
   input  logic       pix_valid,
   input  logic [7:0] pix_data,
   input  logic       pix_last,
   output logic       pix_ready,
   output logic [7:0] tx_wdata,
   output logic       tx_winc,
   input  logic       tx_wfull,
   output logic [1:0] grant,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
   state_t     state;
   logic [1:0] gnt;
   logic       rr_last;
   logic [7:0] cnt;
   logic [1:0] cont;
   logic       sel;
   logic       src_valid;
   logic       src_last;
   logic [7:0] src_data;
   logic [7:0] hdr;
   logic       xfer;
   logic       chunk_end;
   logic       pick_pix;
   // steer the granted source onto the FIFO write port; header bit 0 flags a continuation chunk
   always_comb begin
      sel       = gnt[1];
      src_valid = sel ? pix_valid : cmd_valid;
      src_data  = sel ? pix_data : cmd_data;
      src_last  = sel ? pix_last : cmd_last;
      hdr       = (sel ? PIX_HDR : CMD_HDR) | {7'd0, cont[sel]};
      xfer      = (state == DATA) & src_valid & ~tx_wfull;
      chunk_end = src_last | (cnt == 8'(MAX_BURST - 1));
      pick_pix  = pix_valid & (~cmd_valid | ~rr_last);
      tx_winc   = (state == HDR) ? ~tx_wfull : xfer;
      tx_wdata  = (state == HDR) ? hdr : (state == DATA) ? src_data : 8'd0;
      cmd_ready = (state == DATA) & gnt[0] & ~tx_wfull;
      pix_ready = (state == DATA) & gnt[1] & ~tx_wfull;
      grant     = gnt;
      busy      = state != IDLE;
   end
   // arbitrate in IDLE, emit the header, then count data bytes until end of packet or burst limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt     <= 2'b00;
         rr_last <= 1'b1;
         cnt     <= 8'd0;
         cont    <= 2'b00;
      end else begin
         case (state)
            IDLE: if (cmd_valid | pix_valid) begin
               gnt   <= {pick_pix, ~pick_pix};
               state <= HDR;
            end
            HDR: if (!tx_wfull) begin
               cnt   <= 8'd0;
               state <= DATA;
            end
            DATA: if (xfer) begin
               cnt <= chunk_end ? 8'd0 : cnt + 8'd1;
               if (chunk_end) begin
                  cont[sel] <= ~src_last;
                  rr_last   <= sel;
                  gnt       <= 2'b00;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
